// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type, default constants and byte-merge helper for dmem_hs
package dmem_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  localparam int          DMEM_DATA_W_DEF    = 32;
  localparam int          DMEM_DEPTH_DEF     = 1024;
  localparam logic [31:0] DMEM_INIT_WORD_DEF = 32'hDEADBEEF;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int          MERGE_MAX_W        = 512;

  // Replace the bytes of old_word whose mask bit is set with those of new_word.
  function automatic logic [MERGE_MAX_W-1:0] mask_merge(
    input logic [MERGE_MAX_W-1:0]   old_word,
    input logic [MERGE_MAX_W-1:0]   new_word,
    input logic [MERGE_MAX_W/8-1:0] mask
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_W / 8; i++) begin
      if (mask[i]) begin
        merged[i*8 +: 8] = new_word[i*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with one byte-masked write port and a registered, clearable read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W_DEF,
  parameter int DEPTH  = DMEM_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W/8-1:0] wmask_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  input  logic                rclr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic              w_in_range;
  logic              r_in_range;

  assign w_in_range = (32'(waddr_i) < DEPTH);
  assign r_in_range = (32'(raddr_i) < DEPTH);

  // Build the post-write word from the current contents and the byte mask.
  always_comb begin
    old_word = '0;
    if (w_in_range) begin
      old_word = mem_q[waddr_i];
    end
    merged = DATA_W'(mask_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(wdata_i),
                                (MERGE_MAX_W/8)'(wmask_i)));
  end

  // Commit writes; addresses past the end of the array are dropped.
  always_ff @(posedge clk) begin
    if (we_i && w_in_range) begin
      mem_q[waddr_i] <= merged;
    end
  end

  // Read register: loaded on a read edge, zeroed on reset and on response retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rclr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= r_in_range ? mem_q[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_hs.sv
// rtl/dmem_hs.sv - handshake data memory with init sweep and wait states; DMEM_RANGE_CHECK_EN adds rsp_err
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int                DATA_W    = DMEM_DATA_W_DEF,
  parameter int                DEPTH     = DMEM_DEPTH_DEF,
  parameter int                ADDR_W    = $clog2(DEPTH),
  parameter int                READ_LAT  = 2,
  parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(DMEM_INIT_WORD_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_mask,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
`ifdef DMEM_RANGE_CHECK_EN
  output logic                rsp_err,
`endif
  output logic                init_done
);

  dmem_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              init_done_q;
  logic              accept;

  logic                arr_we;
  logic [ADDR_W-1:0]   arr_waddr;
  logic [DATA_W/8-1:0] arr_wmask;
  logic [DATA_W-1:0]   arr_wdata;
  logic                arr_re;
  logic [ADDR_W-1:0]   arr_raddr;
  logic                arr_rclr;

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q;
`endif

  assign accept = req_valid && req_ready_q;

  // Steer the single array port: sweep writes, request writes, and the read edge.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = req_addr;
    arr_wmask = req_mask;
    arr_wdata = req_wdata;
    arr_re    = 1'b0;
    arr_raddr = addr_q;
    arr_rclr  = 1'b0;
    if (!rst) begin
      case (state_q)
        INIT: begin
          arr_we    = 1'b1;
          arr_waddr = ptr_q;
          arr_wmask = '1;
          arr_wdata = INIT_WORD;
        end
        IDLE: begin
          if (accept) begin
            if (req_we) begin
              arr_we = 1'b1;
            end else if (READ_LAT == 1) begin
              arr_re    = 1'b1;
              arr_raddr = req_addr;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            arr_re = 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            arr_rclr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      ptr_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      init_done_q <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        INIT: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
            req_ready_q <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            addr_q      <= req_addr;
`ifdef DMEM_RANGE_CHECK_EN
            err_q       <= (32'(req_addr) >= DEPTH);
`endif
            if (req_we) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              cnt_q <= 4'(READ_LAT - 1);
              if (READ_LAT == 1) begin
                state_q     <= RESP;
                rsp_valid_q <= 1'b1;
              end else begin
                state_q <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
            err_q       <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wmask_i (arr_wmask),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .raddr_i (arr_raddr),
    .rclr_i  (arr_rclr),
    .rdata_o (rsp_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign init_done = init_done_q;

`ifdef DMEM_RANGE_CHECK_EN
  assign rsp_err = err_q;

  // A pending response may only retire through a handshake (or reset).
  rsp_hold_a: assert property (@(posedge clk) (!rst && rsp_valid_q && !rsp_ready) |=> rsp_valid_q);
`endif

endmodule

// File: tb/tb_dmem_hs.sv
// tb/tb_dmem_hs.sv - directed bench for dmem_hs across three read latencies and a non-power-of-two depth
`timescale 1ns/1ps
module tb_dmem_hs;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst       [N];
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_we    [N];
  logic [9:0]  req_addr  [N];
  logic [3:0]  req_mask  [N];
  logic [31:0] req_wdata [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_rdata [N];
  logic        init_done [N];
`ifdef DMEM_RANGE_CHECK_EN
  logic        rsp_err   [N];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_hs #(.DEPTH(16), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0][3:0]), .req_mask(req_mask[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]),
`ifdef DMEM_RANGE_CHECK_EN
    .rsp_err(rsp_err[0]),
`endif
    .init_done(init_done[0])
  );

  dmem_hs #(.DEPTH(16), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1][3:0]), .req_mask(req_mask[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]),
`ifdef DMEM_RANGE_CHECK_EN
    .rsp_err(rsp_err[1]),
`endif
    .init_done(init_done[1])
  );

  dmem_hs #(.DEPTH(16), .READ_LAT(5)) u_lat5 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2][3:0]), .req_mask(req_mask[2]),
    .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]),
`ifdef DMEM_RANGE_CHECK_EN
    .rsp_err(rsp_err[2]),
`endif
    .init_done(init_done[2])
  );

  dmem_hs #(.DEPTH(1000), .READ_LAT(2)) u_big (
    .clk(clk), .rst(rst[3]), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
    .req_we(req_we[3]), .req_addr(req_addr[3]), .req_mask(req_mask[3]),
    .req_wdata(req_wdata[3]), .rsp_valid(rsp_valid[3]), .rsp_ready(rsp_ready[3]),
    .rsp_rdata(rsp_rdata[3]),
`ifdef DMEM_RANGE_CHECK_EN
    .rsp_err(rsp_err[3]),
`endif
    .init_done(init_done[3])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance k, wait for its response, then retire it.
  task automatic do_req(input int k, input logic we, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        output logic [31:0] rdata, output int lat,
                        output logic rdy_seen, output logic err);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_mask[k]  = mask;
    tick();
    req_valid[k] = 1'b0;
    lat      = 1;
    rdy_seen = 1'b0;
    while (rsp_valid[k] !== 1'b1 && lat < 40) begin
      rdy_seen = rdy_seen | req_ready[k];
      tick();
      lat++;
    end
    rdy_seen = rdy_seen | req_ready[k];
    rdata = rsp_rdata[k];
    err = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    err = rsp_err[k];
`endif
    rsp_ready[k] = 1'b1;
    tick();
    rsp_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    for (int k = 0; k < N; k++) rst[k] = 1'b1;
    tick();
    tick();
    checks++;
    if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready[1]); end
    checks++;
    if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid[1]); end
    checks++;
    if (rsp_rdata[1] !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata[1]); end
    checks++;
    if (init_done[1] !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b want 0", init_done[1]); end
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    n = 0;
    while (init_done[1] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL init_cycles: got %0d want 16", n); end
    checks++;
    if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL init_ready: got %b want 1", req_ready[1]); end
    checks++;
    if (init_done[0] !== 1'b1 || init_done[2] !== 1'b1) begin
      errors++; $display("FAIL init_others: got %b%b want 11", init_done[0], init_done[2]);
    end
  endtask

  task automatic test_init_sweep();
    logic [31:0] d; int lat; logic rs; logic e;
    do_req(1, 1'b0, 10'd5, 32'h0, 4'h0, d, lat, rs, e);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL sweep_rd5: got %h want deadbeef", d); end
  endtask

  task automatic test_masked_write();
    logic [31:0] d; int lat; logic rs; logic e;
    do_req(1, 1'b1, 10'd3, 32'h11223344, 4'b0101, d, lat, rs, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", d); end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL wr_lat: got %0d want 1", lat); end
    do_req(1, 1'b0, 10'd3, 32'h0, 4'h0, d, lat, rs, e);
    checks++;
    if (d !== 32'hDE22BE44) begin errors++; $display("FAIL masked_rd3: got %h want de22be44", d); end
    do_req(1, 1'b0, 10'd4, 32'h0, 4'h0, d, lat, rs, e);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL neighbour_rd4: got %h want deadbeef", d); end
  endtask

  task automatic test_latency();
    int exp_lat [3] = '{1, 2, 5};
    logic [31:0] d; int lat; logic rs; logic e;
    for (int k = 0; k < 3; k++) begin
      do_req(k, 1'b1, 10'd7, 32'hA5A50000 + 32'(k), 4'hF, d, lat, rs, e);
      do_req(k, 1'b0, 10'd7, 32'h0, 4'h0, d, lat, rs, e);
      checks++;
      if (lat != exp_lat[k]) begin errors++; $display("FAIL lat_%0d: got %0d want %0d", k, lat, exp_lat[k]); end
      checks++;
      if (rs !== 1'b0) begin errors++; $display("FAIL lat_ready_%0d: got %b want 0", k, rs); end
      checks++;
      if (d !== 32'hA5A50000 + 32'(k)) begin
        errors++; $display("FAIL lat_data_%0d: got %h want %h", k, d, 32'hA5A50000 + 32'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] d; int lat; logic rs; logic e;
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 10'd3;
    tick();
    req_valid[1] = 1'b0;
    n = 1;
    while (rsp_valid[1] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL bp_lat: got %0d want 2", n); end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hDE22BE44 || req_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b data=%h ready=%b want 1 de22be44 0",
                 i, rsp_valid[1], rsp_rdata[1], req_ready[1]);
      end
    end
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    checks++;
    if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%b data=%h ready=%b want 0 0 1",
               rsp_valid[1], rsp_rdata[1], req_ready[1]);
    end
    do_req(1, 1'b0, 10'd4, 32'h0, 4'h0, d, lat, rs, e);
    checks++;
    if (lat != 2 || d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL back_to_back: got lat=%0d data=%h want 2 deadbeef", lat, d);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    logic seen;
    logic [31:0] d; int lat; logic rs; logic e;
    do_req(2, 1'b1, 10'd9, 32'h12345678, 4'hF, d, lat, rs, e);
    do_req(2, 1'b0, 10'd9, 32'h0, 4'h0, d, lat, rs, e);
    checks++;
    if (d !== 32'h12345678) begin errors++; $display("FAIL mid_pre_rd9: got %h want 12345678", d); end
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 10'd9;
    tick();
    req_valid[2] = 1'b0;
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    checks++;
    if (rsp_valid[2] !== 1'b0 || init_done[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_state: got valid=%b done=%b ready=%b want 0 0 0",
               rsp_valid[2], init_done[2], req_ready[2]);
    end
    n = 0;
    seen = 1'b0;
    while (init_done[2] !== 1'b1 && n < 100) begin
      tick();
      n++;
      seen = seen | rsp_valid[2];
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: got %b want 0", seen); end
    checks++;
    if (n != 16) begin errors++; $display("FAIL mid_resweep: got %0d want 16", n); end
    do_req(2, 1'b0, 10'd9, 32'h0, 4'h0, d, lat, rs, e);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_post_rd9: got %h want deadbeef", d); end
  endtask

  task automatic test_range();
    int n;
    logic [31:0] d; int lat; logic rs; logic e;
    n = 0;
    while (init_done[3] !== 1'b1 && n < 1200) begin
      tick();
      n++;
    end
    checks++;
    if (init_done[3] !== 1'b1) begin errors++; $display("FAIL big_init: got %b want 1", init_done[3]); end
    do_req(3, 1'b1, 10'd1010, 32'hFFFFFFFF, 4'hF, d, lat, rs, e);
    checks++;
    if (d !== 32'h0 || lat != 1) begin errors++; $display("FAIL oor_wr: got data=%h lat=%0d want 0 1", d, lat); end
`ifdef DMEM_RANGE_CHECK_EN
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", e); end
`endif
    do_req(3, 1'b0, 10'd1010, 32'h0, 4'h0, d, lat, rs, e);
    checks++;
    if (d !== 32'h0 || lat != 2) begin errors++; $display("FAIL oor_rd: got data=%h lat=%0d want 0 2", d, lat); end
`ifdef DMEM_RANGE_CHECK_EN
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b want 1", e); end
`endif
    do_req(3, 1'b1, 10'd999, 32'hCAFEF00D, 4'hF, d, lat, rs, e);
    do_req(3, 1'b0, 10'd999, 32'h0, 4'h0, d, lat, rs, e);
    checks++;
    if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL last_rd999: got %h want cafef00d", d); end
`ifdef DMEM_RANGE_CHECK_EN
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL last_err: got %b want 0", e); end
`endif
    do_req(3, 1'b0, 10'd998, 32'h0, 4'h0, d, lat, rs, e);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL big_rd998: got %h want deadbeef", d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      rst[k]       = 1'b1;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_mask[k]  = '0;
      req_wdata[k] = '0;
      rsp_ready[k] = 1'b0;
    end
    test_reset();
    test_init_sweep();
    test_masked_write();
    test_latency();
    test_backpressure();
    test_reset_mid_wait();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
